// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding, load/branch/mult-div stalls,
// a HI/LO latency tracker for the multi-cycle mult/div unit and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int REGW   = 5,
  parameter int MD_LAT = 4,
  parameter int CNTW   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsd,
  input  logic [REGW-1:0] rtd,
  input  logic [REGW-1:0] rse,
  input  logic [REGW-1:0] rte,
  input  logic [REGW-1:0] writerege,
  input  logic [REGW-1:0] writeregm,
  input  logic [REGW-1:0] writeregw,
  input  logic            regwritee,
  input  logic            regwritem,
  input  logic            regwritew,
  input  logic            memtorege,
  input  logic            memtoregm,
  input  logic            branchd,
  input  logic            mdstartd,
  input  logic            mdreadd,
  output logic            stallf,
  output logic            stalld,
  output logic            flushe,
  output logic            forwardad,
  output logic            forwardbd,
  output logic [1:0]      forwardae,
  output logic [1:0]      forwardbe,
  output logic            mdbusy,
  output logic [CNTW-1:0] stall_cycles
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(MD_LAT - 1);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t     state;
  logic [CW-1:0] cnt;
  logic          lwstall, brstall, mdstall, hazard, accept;
  logic          e_hits_d, m_hits_d;

  // Forwarding: M stage has priority over W since it holds the younger result.
  always_comb begin
    forwardae = 2'b00;
    forwardbe = 2'b00;
    if (!reset) begin
      if (rse != '0 && rse == writeregm && regwritem)      forwardae = 2'b10;
      else if (rse != '0 && rse == writeregw && regwritew) forwardae = 2'b01;
      if (rte != '0 && rte == writeregm && regwritem)      forwardbe = 2'b10;
      else if (rte != '0 && rte == writeregw && regwritew) forwardbe = 2'b01;
    end
  end

  assign forwardad = !reset && rsd != '0 && rsd == writeregm && regwritem;
  assign forwardbd = !reset && rtd != '0 && rtd == writeregm && regwritem;

  assign lwstall  = memtorege && rte != '0 && (rsd == rte || rtd == rte);
  assign e_hits_d = regwritee && writerege != '0 && (writerege == rsd || writerege == rtd);
  assign m_hits_d = memtoregm && writeregm != '0 && (writeregm == rsd || writeregm == rtd);
  assign brstall  = branchd && (e_hits_d || m_hits_d);
  // Depends only on registered tracker state, so accept below cannot loop back into it.
  assign mdstall  = state == BUSY && cnt != '0 && (mdstartd || mdreadd);
  assign hazard   = lwstall || brstall || mdstall;
  assign accept   = mdstartd && !hazard;

  assign stalld = hazard && !reset;
  assign stallf = stalld;
  assign flushe = hazard || reset;
  assign mdbusy = state == BUSY && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            cnt   <= RELOAD;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (accept) begin
            cnt <= RELOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stalld && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + CNTW'(1);
    end
  end

endmodule
